// File: rtl/cache_arb.sv
// cache_arb: round-robin two-port command arbiter/sequencer in front of the shared 2-way cache.
// Latency: gnt/mem_req one cycle after req is sampled; rvalid one cycle after mem_ack (ack in ISSUE -> rvalid next cycle).
// Backpressure: one command in flight; the losing requester holds req in IDLE until granted; a silent cache aborts after TIMEOUT WAIT cycles.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN/wrN/addrN/wdataN       requester N command (held until gntN)
//   gntN, rvalidN               one-cycle accept / completion pulses to requester N
//   rdata, miss, err            completion payload, valid with rvalidN
//   mem_req/wr/addr/wdata       command to the cache (addr/wr/wdata stable from ISSUE to end of WAIT)
//   mem_ack/rdata/miss          completion from the cache
//   hit_cnt, miss_cnt           saturating statistics, present only with CACHE_ARB_STATS_EN defined
module cache_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              miss,
  output logic              err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_miss
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t     state_q, state_d;
  cmd_t       cmd_q;
  logic       winner_q;   // port that owns the command in flight
  logic       ptr_q;      // 1: port 1 has priority on the next contention
  logic       pick1;      // IDLE arbitration result
  logic [7:0] wait_cnt;   // cycles since ISSUE; WAIT therefore lasts at most TIMEOUT cycles
  logic       ack_ok;     // mem_ack only counts while a command is outstanding
  logic       timed_out;

  assign pick1     = req1 && (!req0 || ptr_q);
  assign ack_ok    = mem_ack && (state_q == ISSUE || state_q == WAIT);
  assign timed_out = (state_q == WAIT) && !mem_ack && (wait_cnt == TIMEOUT_L);

  assign mem_wr    = cmd_q.wr;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  // Next state and state-decoded strobes; nothing here depends on req* or mem_ack
  // except the next-state choice, so outputs stay free of input-to-output paths.
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) state_d = ISSUE;
      end
      ISSUE: begin
        gnt0    = !winner_q;
        gnt1    = winner_q;
        mem_req = 1'b1;
        state_d = mem_ack ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_ack || timed_out) state_d = RESP;
      end
      RESP: begin
        rvalid0 = !winner_q;
        rvalid1 = winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      winner_q <= 1'b0;
      ptr_q    <= 1'b0;
      wait_cnt <= '0;
      rdata    <= '0;
      miss     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          wait_cnt <= '0;
          if (req0 || req1) begin
            winner_q <= pick1;
            cmd_q    <= pick1 ? {wr1, addr1, wdata1} : {wr0, addr0, wdata0};
          end
        end
        ISSUE, WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (mem_ack) begin
            rdata <= cmd_q.wr ? '0 : mem_rdata;
            miss  <= mem_miss;
            err   <= 1'b0;
          end else if (timed_out) begin
            rdata <= '0;
            miss  <= 1'b0;
            err   <= 1'b1;
          end
        end
        RESP: begin
          // Completion payload is only meaningful alongside rvalid; clear it afterwards.
          ptr_q <= !winner_q;
          rdata <= '0;
          miss  <= 1'b0;
          err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (ack_ok) begin
      if (mem_miss) begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end else if (!cmd_q.wr) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_ack_ok;
  assign unused_ack_ok = ack_ok;
`endif

endmodule

// File: tb/tb_cache_arb.sv
module tb_cache_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          miss, err;
  logic          mem_req, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_miss;
`ifdef CACHE_ARB_STATS_EN
  logic [SW-1:0] hit_cnt, miss_cnt;
`endif

  cache_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .miss(miss), .err(err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_miss(mem_miss)
`ifdef CACHE_ARB_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
    logic          miss;
    logic          err;
  } rsp_t;
  rsp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_ARB_STATS_EN
    check({tag, "_hit_cnt"}, 64'(hit_cnt), 64'(exp_hit));
    check({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_miss));
`else
    if (tag.len() == 0) $display("stats disabled");
`endif
  endtask

  // Waits (bounded) for a grant; returns the cycle of the ISSUE cycle.
  task automatic wait_gnt(input logic exp_port, output int gcyc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) break;
    end
    check("gnt_seen", 64'(gnt0 | gnt1), 1);
    check("gnt_port", {gnt1, gnt0}, exp_port ? 2'b10 : 2'b01);
    check("gnt_mem_req", 64'(mem_req), 1);
    gcyc = cyc;
  endtask

  // Drives one mem_ack pulse `delay` cycles after the current (grant) cycle and
  // records the completion the requester should see.
  task automatic ack(input int delay, input logic exp_port, input logic is_wr,
                     input logic [DW-1:0] d, input logic m);
    rsp_t e;
    repeat (delay) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = d; mem_miss = m;
    e.port = exp_port; e.rdata = is_wr ? '0 : d; e.miss = m; e.err = 1'b0;
    sb.push_back(e);
    if (m) exp_miss++;
    else if (!is_wr) exp_hit++;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0; mem_miss = 1'b0;
  endtask

  // Waits (bounded) for rvalid, starting with the current cycle, and checks it
  // against the oldest expected completion.
  task automatic wait_rsp(output int rcyc);
    rsp_t e;
    for (int i = 0; i < 300; i++) begin
      if (rvalid0 || rvalid1) break;
      @(negedge clk);
    end
    check("rvalid_seen", 64'(rvalid0 | rvalid1), 1);
    rcyc = cyc;
    if (rvalid0 || rvalid1) begin
      check("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_port", {rvalid1, rvalid0}, e.port ? 2'b10 : 2'b01);
        check("rsp_rdata", 64'(rdata), 64'(e.rdata));
        check("rsp_miss", 64'(miss), 64'(e.miss));
        check("rsp_err", 64'(err), 64'(e.err));
      end
    end
  endtask

  initial begin
    int g, r;
    rsp_t e;
    rst_n = 1'b0;
    req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    mem_ack = 0; mem_rdata = '0; mem_miss = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ctrl", {gnt0, gnt1, rvalid0, rvalid1, mem_req, mem_wr, err, miss}, 0);
    check("reset_rdata_addr", {rdata, mem_addr}, 0);
    check("reset_wdata", 64'(mem_wdata), 0);
    check_stats("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", {gnt0, gnt1, mem_req, rvalid0, rvalid1}, 0);

    // Single read on port 0, miss, ack two cycles after mem_req
    req0 = 1; wr0 = 0; addr0 = 32'h10;
    wait_gnt(1'b0, g);
    check("rd_mem_addr", 64'(mem_addr), 32'h10);
    check("rd_mem_wr", 64'(mem_wr), 0);
    req0 = 0;
    @(negedge clk);
    check("gnt_one_cycle", {gnt0, gnt1, mem_req}, 0);
    check("wait_addr_stable", 64'(mem_addr), 32'h10);
    ack(1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    wait_rsp(r);
    check("read_span", 64'(r - g + 1), 4);
    check_stats("single_read");
    @(negedge clk);
    check("rvalid_one_cycle", {rvalid0, rvalid1, rdata}, 0);

    // Write on port 1: rdata forced to 0, hit counter untouched
    req1 = 1; wr1 = 1; addr1 = 32'h24; wdata1 = 32'h5;
    wait_gnt(1'b1, g);
    check("wr_mem_wr", 64'(mem_wr), 1);
    check("wr_mem_addr", 64'(mem_addr), 32'h24);
    check("wr_mem_wdata", 64'(mem_wdata), 32'h5);
    req1 = 0; wr1 = 0;
    ack(1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    wait_rsp(r);
    check_stats("write");

    // Contention: both ports held for four transactions each -> 0,1,0,1,...
    addr0 = 32'h100; addr1 = 32'h200;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 8; i++) begin
      logic p;
      p = (i % 2) != 0;
      wait_gnt(p, g);
      check("rr_mem_addr", 64'(mem_addr), p ? 32'h200 : 32'h100);
      if (p) req1 = 0; else req0 = 0;
      ack(i % 3, p, 1'b0, 32'hA000_0000 + i, (i % 3) == 1);
      wait_rsp(r);
      if (i % 3 == 0) check("ack_in_issue_span", 64'(r - g + 1), 2);
      if (i + 2 < 8) begin
        if (p) req1 = 1; else req0 = 1;
      end
    end
    check_stats("contention");

    // Timeout: no ack, err completion spans TIMEOUT+2 cycles from the gnt cycle
    req0 = 1; addr0 = 32'h40;
    e.port = 1'b0; e.rdata = '0; e.miss = 1'b0; e.err = 1'b1;
    sb.push_back(e);
    wait_gnt(1'b0, g);
    req0 = 0;
    wait_rsp(r);
    check("timeout_span", 64'(r - g + 1), TO + 2);
    // Late ack in IDLE is ignored
    @(negedge clk);
    mem_ack = 1; mem_miss = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 0; mem_miss = 0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      check("late_ack_quiet", {rvalid0, rvalid1, mem_req, err, miss, rdata}, 0);
      @(negedge clk);
    end
    check_stats("late_ack");

    // Reset in WAIT: pointer currently favours port 1; reset must bring it back to port 0
    req0 = 1; addr0 = 32'h80;
    wait_gnt(1'b0, g);
    req0 = 0;
    @(negedge clk);
    check("pre_reset_addr", 64'(mem_addr), 32'h80);
    rst_n = 0;
    #1;
    check("async_reset_ctrl", {gnt0, gnt1, rvalid0, rvalid1, mem_req, mem_wr, err, miss}, 0);
    check("async_reset_data", {rdata, mem_addr}, 0);
    exp_hit = 0; exp_miss = 0;
    check_stats("async_reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < TO + 3; i++) begin
      @(negedge clk);
      check("no_rvalid_after_abort", {rvalid0, rvalid1}, 0);
    end
    req0 = 1; req1 = 1; addr0 = 32'h300; addr1 = 32'h400;
    wait_gnt(1'b0, g);
    req0 = 0;
    ack(0, 1'b0, 1'b0, 32'h1234, 1'b0);
    wait_rsp(r);
    wait_gnt(1'b1, g);
    check("post_reset_p1_addr", 64'(mem_addr), 32'h400);
    req1 = 0;
    ack(2, 1'b1, 1'b0, 32'h5678, 1'b1);
    wait_rsp(r);
    check_stats("post_reset");
    check("sb_drained", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_arb.md
# cache_arb

Two-port request arbiter and sequencer in front of the shared 2-way cache. Requester 0 (instruction fetch) and requester 1 (data load/store) each issue single read or write commands. The block grants one command at a time by round-robin, drives the cache command interface, waits for completion with a timeout, and returns the read data and hit/miss status to the winner.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum WAIT cycles before abort (1..255)
- STAT_W, 16, statistics counter width
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  command request, held until matching gnt
- wr0 / wr1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  command address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: command accepted
- rvalid0 / rvalid1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid with rvalid*; 0 for writes and errors
- miss  out  1  completion was a cache miss; valid with rvalid*
- err  out  1  completion was a timeout; valid with rvalid*
- mem_req  out  1  one-cycle command strobe to the cache
- mem_wr, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  latched command, stable from ISSUE until leaving WAIT
- mem_ack  in  1  completion pulse from the cache
- mem_rdata  in  DATA_W  cache read data, valid with mem_ack
- mem_miss  in  1  cache miss flag, valid with mem_ack
- hit_cnt, miss_cnt  out  STAT_W  statistics (CACHE_ARB_STATS_EN only)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state: IDLE.
- IDLE: with no request, stay in IDLE. With one request, grant it. With both requests, grant the port that did not win last. The priority pointer resets to "port 0 next". On a grant, latch wr/addr/wdata and the winner ID, then go to ISSUE.
- ISSUE (1 cycle): gnt of the winner = 1, mem_req = 1. Next state is WAIT. If mem_ack = 1 in this cycle, go directly to RESP.
- WAIT: wait_cnt counts up each cycle. On mem_ack, capture rdata (mem_rdata for reads, 0 for writes) and miss, then go to RESP. When wait_cnt == TIMEOUT, go to RESP with err = 1, rdata = 0, miss = 0.
- RESP (1 cycle): rvalid of the winner = 1. Flip the priority pointer to the other port. Return to IDLE.
- mem_ack outside ISSUE/WAIT (e.g. a late ack after a timeout) is ignored. It does not change any counter.
- Each requester sees at most one outstanding command. It must not re-raise req until after its rvalid.

## Timing
- Reset values: gnt0/1, rvalid0/1, mem_req, mem_wr, err, miss = 0. rdata, mem_addr, mem_wdata = 0. wait_cnt = 0. hit_cnt, miss_cnt = 0.
- All outputs are registered or decoded from state. There is no combinational path from req* or mem_ack to any output.
- Request sampled at edge E: gnt and mem_req high in cycle E+1.
- mem_ack sampled at edge A: rvalid high in cycle A+1.
- Minimum turnaround is 3 cycles (ack in the ISSUE cycle). Back-to-back grants are separated by the RESP and IDLE cycles.
- Timeout: rvalid with err appears TIMEOUT+2 cycles after gnt.
- rst_n asserted mid-transaction aborts the command immediately. No rvalid is produced. The pointer returns to port 0.

## Configuration
- CACHE_ARB_STATS_EN defined:
  - hit_cnt increments on each ack of a read with mem_miss = 0.
  - miss_cnt increments on each ack with mem_miss = 1.
  - Both counters saturate at all ones.
- CACHE_ARB_STATS_EN undefined: the hit_cnt and miss_cnt ports and their logic are absent. All other behaviour is identical.

## Test plan
- Single read: req0 read addr 0x10, mem_ack 2 cycles after mem_req with rdata 0xDEADBEEF, mem_miss = 1 -> gnt0 one cycle, rvalid0 with rdata 0xDEADBEEF, miss = 1, miss_cnt = 1.
- Contention: req0 and req1 raised together and held for 4 transactions each -> grants alternate 0,1,0,1. No port starves.
- Write: req1 write addr 0x24 data 0x5 -> mem_wr = 1, mem_addr = 0x24, mem_wdata = 0x5. On ack: rvalid1, rdata = 0, hit_cnt unchanged.
- Timeout with TIMEOUT = 4: mem_ack never returned -> rvalid with err = 1 exactly 6 cycles after gnt. A late mem_ack in IDLE is ignored.
- Reset mid-WAIT: rst_n low for 1 cycle -> all outputs return to 0 asynchronously. The next simultaneous req0/req1 grants port 0.
- Ack in the ISSUE cycle: rvalid appears 2 cycles after gnt.
